// File: rtl/dmem_resp.sv
// dmem_resp: MEM-stage data-memory responder in front of a one-cycle-latency,
// whole-word-write BRAM. Sub-word loads are lane-selected and extended; sub-word
// stores are a read followed by a merged write-back.
// Optional build macro: DMEM_MISALIGN_CHECK_EN adds rsp_err and rejects misaligned
// half/word requests instead of force-aligning them.
module dmem_resp #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic              rsp_err,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LD_WAIT  = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        offQ;
    logic [1:0]        sizeQ;
    logic              unsQ;
    logic [15:0]       wdataQ;
    logic [ADDR_W-1:0] waddrQ;

    logic        accept;
    logic        isWord;
    logic        misaligned;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] loadData;
    logic [31:0] mergeData;

    // Address bits above the BRAM range are intentionally dropped.
    logic unusedAddr;
    assign unusedAddr = ^req_addr[31:ADDR_W+2];

    assign req_ready = rst & (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign isWord    = req_size[1];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = ((req_size == 2'b01) & req_addr[0]) |
                        (isWord & (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Lane select and sign/zero extension of the returning BRAM word.
    always_comb begin
        unique case (offQ)
            2'd0:    byteLane = mem_dout[7:0];
            2'd1:    byteLane = mem_dout[15:8];
            2'd2:    byteLane = mem_dout[23:16];
            default: byteLane = mem_dout[31:24];
        endcase
        halfLane = offQ[1] ? mem_dout[31:16] : mem_dout[15:0];
        unique case (sizeQ)
            2'b00:   loadData = {{24{~unsQ & byteLane[7]}}, byteLane};
            2'b01:   loadData = {{16{~unsQ & halfLane[15]}}, halfLane};
            default: loadData = mem_dout;
        endcase
    end

    // Replace the target lane of the read-back word with the latched store data.
    always_comb begin
        mergeData = mem_dout;
        if (sizeQ == 2'b00) begin
            mergeData[{offQ, 3'b000} +: 8] = wdataQ[7:0];
        end else begin
            mergeData[{offQ[1], 4'b0000} +: 16] = wdataQ;
        end
    end

    // BRAM port: pass-through in IDLE, merged write-back in ST_MERGE; writes gated by rst.
    always_comb begin
        mem_addr = req_addr[ADDR_W+1:2];
        mem_din  = req_wdata;
        mem_we   = 1'b0;
        if (state == ST_MERGE) begin
            mem_addr = waddrQ;
            mem_din  = mergeData;
            mem_we   = rst;
        end else if (accept && req_we && isWord && !misaligned) begin
            mem_we = 1'b1;
        end
    end

    // Request FSM and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            offQ      <= 2'd0;
            sizeQ     <= 2'd0;
            unsQ      <= 1'b0;
            wdataQ    <= 16'd0;
            waddrQ    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misaligned || (req_we && isWord)) begin
                            // Completed in the accept cycle: word store or rejected request.
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            offQ   <= req_addr[1:0];
                            sizeQ  <= req_size;
                            unsQ   <= req_unsigned;
                            wdataQ <= req_wdata[15:0];
                            waddrQ <= req_addr[ADDR_W+1:2];
                            state  <= req_we ? ST_MERGE : LD_WAIT;
                        end
                    end
                end
                LD_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= loadData;
                    state     <= IDLE;
                end
                ST_MERGE: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'd0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    // Error flag is only set for a rejected request and cleared on every other response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= accept & misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: behavioural BRAM, request driver, response scoreboard.
module tb_dmem_resp;

    localparam int unsigned AW = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_unsigned, req_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        mem_we;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        rsp_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] bram [0:(1<<AW)-1];
    logic [31:0] refm [0:15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency read-first BRAM.
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    dmem_resp #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef DMEM_MISALIGN_CHECK_EN
        .rsp_err(rsp_err),
`endif
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    // Scoreboard: every response pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        logic gotErr;
        if (rsp_valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h at cycle %0d, required none",
                         rsp_rdata, cyc);
            end else begin
                e = sbq.pop_front();
`ifdef DMEM_MISALIGN_CHECK_EN
                gotErr = rsp_err;
`else
                gotErr = 1'b0;
`endif
                if (rsp_rdata !== e.rdata || cyc != e.cyc || gotErr !== e.err) begin
                    errors++;
                    $display("FAIL rsp: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                             rsp_rdata, gotErr, cyc, e.rdata, e.err, e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge where the next request may be driven.
    task automatic doReq(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRdata, input logic expErr, input int lat,
                         input logic [31:0] expDin);
        exp_t e;
        logic expWe;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: req_ready=%b, required 1", req_ready);
        end
        expWe = we && (lat == 1) && !expErr;
        checks++;
        if (mem_we !== expWe ||
            (expWe && (mem_din !== wdata || mem_addr !== addr[AW+1:2]))) begin
            errors++;
            $display("FAIL issue_port: we=%b din=%h addr=%h, required we=%b din=%h addr=%h",
                     mem_we, mem_din, mem_addr, expWe, wdata, addr[AW+1:2]);
        end
        e.rdata = expRdata; e.err = expErr; e.cyc = cyc + lat;
        sbq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (lat == 2) begin
            #1;
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready: req_ready=%b, required 0", req_ready);
            end
            checks++;
            if (mem_we !== we ||
                (we && (mem_din !== expDin || mem_addr !== addr[AW+1:2]))) begin
                errors++;
                $display("FAIL second_port: we=%b din=%h addr=%h, required we=%b din=%h addr=%h",
                         mem_we, mem_din, mem_addr, we, expDin, addr[AW+1:2]);
            end
            @(negedge clk);
        end
    endtask

    task automatic storeW(input logic [31:0] addr, input logic [31:0] data);
        doReq(1'b1, 2'b10, 1'b0, addr, data, 32'd0, 1'b0, 1, 32'd0);
    endtask

    task automatic storeSub(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] merged);
        doReq(1'b1, size, 1'b0, addr, data, 32'd0, 1'b0, 2, merged);
    endtask

    task automatic load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] expv);
        doReq(1'b0, size, uns, addr, 32'hCAFE_F00D, expv, 1'b0, 2, 32'd0);
    endtask

    function automatic logic [31:0] ldModel(input logic [31:0] w, input int size,
                                            input logic uns, input int off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = w[16*(off/2) +: 16];
        if (size == 0) return uns ? {24'd0, b} : {{24{b[7]}}, b};
        if (size == 1) return uns ? {16'd0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] mergeModel(input logic [31:0] w, input int size,
                                               input logic [31:0] d, input int off);
        logic [31:0] r;
        r = w;
        if (size == 0) r[8*off +: 8] = d[7:0];
        else r[16*(off/2) +: 16] = d[15:0];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem_we: mem_we=%b in reset cycle %0d, required 0", mem_we, i);
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: valid=%b rdata=%h ready=%b, required 0 0 0",
                         rsp_valid, rsp_rdata, req_ready);
            end
        end
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        storeW(32'h10, 32'hDEAD_BEEF);
        load(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (rsp_rdata !== 32'hDEAD_BEEF || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdata_hold: rdata=%h valid=%b, required DEADBEEF 0",
                     rsp_rdata, rsp_valid);
        end
    endtask

    task automatic test_subword_store();
        storeW(32'h20, 32'h1122_3344);
        storeSub(2'b00, 32'h22, 32'h0000_00AA, 32'h11AA_3344);
        load(2'b10, 1'b0, 32'h20, 32'h11AA_3344);
        storeW(32'h24, 32'h1122_3344);
        storeSub(2'b01, 32'h26, 32'hFFFF_5566, 32'h5566_3344);
        load(2'b10, 1'b0, 32'h24, 32'h5566_3344);
    endtask

    task automatic test_load_ext();
        storeW(32'h30, 32'h80FF_7F01);
        load(2'b00, 1'b0, 32'h32, 32'hFFFF_FFFF);
        load(2'b00, 1'b1, 32'h32, 32'h0000_00FF);
        load(2'b01, 1'b0, 32'h32, 32'hFFFF_80FF);
        load(2'b01, 1'b1, 32'h30, 32'h0000_7F01);
        load(2'b00, 1'b0, 32'h30, 32'h0000_0001);
        load(2'b11, 1'b1, 32'h30, 32'h80FF_7F01);
    endtask

    task automatic test_abort();
        storeW(32'h20, 32'h1122_3344);
        // Byte store, then reset during the merge cycle.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h20;
        req_wdata = 32'h77;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_store_we: mem_we=%b, required 0", mem_we);
        end
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_store_rsp: rsp_valid=%b, required 0", rsp_valid);
        end
        // Load, then reset during the wait cycle.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_load: rsp_valid=%b ready=%b, required 0 1", rsp_valid, req_ready);
        end
        load(2'b10, 1'b0, 32'h20, 32'h1122_3344);
    endtask

    task automatic test_misalign();
        storeW(32'h30, 32'h80FF_7F01);
`ifdef DMEM_MISALIGN_CHECK_EN
        doReq(1'b0, 2'b10, 1'b0, 32'h31, 32'd0, 32'd0, 1'b1, 1, 32'd0);
        doReq(1'b1, 2'b01, 1'b0, 32'h33, 32'h5A5A, 32'd0, 1'b1, 1, 32'd0);
        load(2'b10, 1'b0, 32'h30, 32'h80FF_7F01);
`else
        load(2'b10, 1'b0, 32'h31, 32'h80FF_7F01);
        load(2'b01, 1'b0, 32'h33, 32'hFFFF_80FF);
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) storeW(32'h40 + 4 * i, 32'hA5A5_0000 + i);
        for (int i = 0; i < 4; i++) load(2'b10, 1'b0, 32'h40 + 4 * i, 32'hA5A5_0000 + i);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            refm[i] = $urandom;
            storeW(32'h100 + 4 * i, refm[i]);
        end
        for (int n = 0; n < 40; n++) begin
            int idx, off, size;
            logic we, uns;
            logic [31:0] d, m;
            idx = $urandom_range(0, 15);
            size = $urandom_range(0, 2);
            off = (size == 0) ? $urandom_range(0, 3) : (size == 1) ? 2 * $urandom_range(0, 1) : 0;
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            d = $urandom;
            if (we && size == 2) begin
                storeW(32'h100 + 4 * idx, d);
                refm[idx] = d;
            end else if (we) begin
                m = mergeModel(refm[idx], size, d, off);
                storeSub(2'(size), 32'h100 + 4 * idx + off, d, m);
                refm[idx] = m;
            end else begin
                load(2'(size), uns, 32'h100 + 4 * idx + off, ldModel(refm[idx], size, uns, off));
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_load_ext();
        test_abort();
        test_misalign();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Responder side of the MEM-stage data-memory interface.
- Accepts load/store requests from the pipeline's memory stage and drives a single-port synchronous BRAM. The BRAM has one-cycle read latency and a single whole-word write enable.
- Provides byte, halfword and word access: sub-word loads are sign/zero extended; sub-word stores are done by read-modify-write.
- Returns a response pulse with load data, and holds off new requests via req_ready while busy.

Parameters:
ADDR_W, 14, word-address width to the BRAM (depth = 2^ADDR_W words)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, 1 = run)
req_valid  input  1  request present this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address (from ALU result)
req_wdata  input  32  store data, right-justified
req_ready  output  1  request accepted when req_valid & req_ready
rsp_valid  output  1  one-cycle pulse; request completed
rsp_rdata  output  32  extended load data; 0 for stores
mem_addr  output  ADDR_W  word address = addr[ADDR_W+1:2]; upper address bits ignored
mem_din  output  32  BRAM write data
mem_we  output  1  BRAM write enable
mem_dout  input  32  BRAM read data; valid one cycle after mem_addr is presented

Behaviour:
- States: IDLE, LD_WAIT, ST_MERGE. req_ready = rst & (state==IDLE).
- Reset (rst==0 at an edge):
  - state<=IDLE; rsp_valid<=0; rsp_rdata<=0; latched request fields<=0.
  - mem_we is gated combinationally by rst, so it is 0 in any cycle with rst==0.
- IDLE, accept in cycle N:
  - mem_addr is driven combinationally from req_addr.
  - Word store: mem_we=1 and mem_din=req_wdata in cycle N; stay IDLE; rsp_valid=1 in N+1 with rsp_rdata=0.
  - Load: latch addr[1:0], size and unsigned; go to LD_WAIT.
  - Sub-word store: latch addr[1:0], size and wdata; issue the read in N; go to ST_MERGE.
- LD_WAIT (N+1):
  - Select the lane from mem_dout, little-endian: byte = addr[1:0]*8, half = addr[1]*16.
  - Extend per req_unsigned; register into rsp_rdata.
  - rsp_valid=1 in N+2; go to IDLE.
- ST_MERGE (N+1):
  - mem_addr = latched word address, mem_we=1.
  - mem_din = mem_dout with the target lane replaced by wdata[7:0] (byte) or wdata[15:0] (half).
  - rsp_valid=1 in N+2 with rsp_rdata=0; go to IDLE.
- Throughput: back-to-back word stores are accepted every cycle; loads and sub-word stores accept one request per 2 cycles.
- rsp_valid is a single-cycle pulse. rsp_rdata holds its value until the next response.
- Idle outputs (no accept): mem_we=0; mem_addr follows req_addr; mem_din=req_wdata.
- Alignment, macro off: low address bits below the access size are ignored; access is forced aligned.
- Reset mid-operation:
  - rst==0 during LD_WAIT aborts the load; no rsp_valid.
  - rst==0 during ST_MERGE suppresses the write (mem_we=0); memory is unchanged.
- req_valid while req_ready==0 is ignored (not queued). The requester holds the request until accepted.

Optional Feature:
Macro DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Adds output port rsp_err (1 bit); reset value 0.
  - A misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) is accepted in IDLE with no memory access (mem_we=0).
  - rsp_valid=1 and rsp_err=1 in N+1; rsp_rdata=0.
  - rsp_err=0 on all other responses.
- Not defined: no rsp_err port; misaligned requests are silently aligned as above.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1, req_we=1 -> mem_we=0 throughout; rsp_valid=0 and rsp_rdata=0 after the first edge.
- Word store then load: store 0xDEADBEEF at 0x10, then load word at 0x10 -> write rsp_valid at N+1; load rsp_rdata=0xDEADBEEF at N+2; req_ready=0 for one cycle.
- Sub-word store: mem word 0x11223344 at 0x20, store byte 0xAA to 0x22 -> mem_we in ST_MERGE with mem_din=0x11AA3344; follow-up word load returns 0x11AA3344.
- Load extension: word 0x80FF7F01 at 0x30 ->
  - lb 0x32 = 0xFFFFFFFF; lbu 0x32 = 0x000000FF.
  - lh 0x32 = 0xFFFF80FF; lhu 0x30 = 0x00007F01.
- Abort: start a byte store to 0x20, drive rst=0 in the ST_MERGE cycle -> no mem_we; memory still 0x11223344; no rsp_valid.
- Feature on: word load at 0x31 -> rsp_valid and rsp_err=1 at N+1, rsp_rdata=0, no BRAM write. Feature off: same request returns the word at 0x30 at N+2.
